// File: rtl/demux_1x4_tdm.sv
// demux_1x4_tdm: TDM demultiplexer, one interleaved sample stream to NUM_CH valid/ready channels
//   clk, rst_n            clock, async active-low reset
//   in_data/in_valid/in_sof/in_ready   interleaved input stream, in_sof marks the channel-0 sample
//   out_data/out_valid/out_ready       per-channel output registers, channel c at [c*DATA_W +: DATA_W]
//   sel                   channel the next non-SOF sample targets
//   locked, sync_err      frame lock status and one-cycle misalignment pulse
module demux_1x4_tdm #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     in_sof,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [SEL_W-1:0]         sel,
  output logic                     locked,
  output logic                     sync_err
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d, tgt;
  logic [NUM_CH*DATA_W-1:0]  data_q, data_d;
  logic [NUM_CH-1:0]         valid_q, valid_d, wr;
  logic                      sync_err_q, sync_err_d, acc;
  always_comb begin
    tgt = in_sof ? '0 : sel_q;
    // HUNT keeps the link drained; only an SOF sample is actually taken
    in_ready = (state_q == HUNT) | ~valid_q[tgt] | out_ready[tgt];
    acc = in_valid & in_ready & ((state_q == LOCKED) | in_sof);
    wr = acc ? ({{(NUM_CH-1){1'b0}}, 1'b1} << tgt) : '0;
    sel_d = acc ? ((tgt == SEL_W'(NUM_CH-1)) ? '0 : tgt + 1'b1) : sel_q;
    state_d = acc ? LOCKED : state_q;
    sync_err_d = acc & in_sof & (state_q == LOCKED) & (sel_q != '0);
    // a write in the same cycle as a drain keeps the channel full with no bubble
    valid_d = wr | (valid_q & ~out_ready);
    data_d = data_q;
    for (int c = 0; c < NUM_CH; c++)
      data_d[c*DATA_W +: DATA_W] = wr[c] ? in_data : data_q[c*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      sel_q      <= '0;
      data_q     <= '0;
      valid_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
    end
  end
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign sel       = sel_q;
  assign locked    = (state_q == LOCKED);
  assign sync_err  = sync_err_q;
endmodule

// File: tb/tb_demux_1x4_tdm.sv
// tb_demux_1x4_tdm: randomized and directed bench against a per-channel behavioural model
module tb_demux_1x4_tdm;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid, in_sof, in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid, out_ready;
  logic [1:0]  sel;
  logic        locked, sync_err;
  int          checks = 0;
  int          errors = 0;
  bit          m_locked, m_serr;
  int          m_sel;
  bit          m_valid[4];
  logic [7:0]  m_last[4];
  demux_1x4_tdm #(.DATA_W(8), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel(sel), .locked(locked), .sync_err(sync_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_locked = 0;
    m_serr = 0;
    m_sel = 0;
    for (int c = 0; c < 4; c++) begin
      m_valid[c] = 0;
      m_last[c] = 8'h00;
    end
  endtask
  task automatic check_outputs();
    chk("locked", locked, m_locked);
    chk("sel", sel, m_sel);
    chk("sync_err", sync_err, m_serr);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("out_valid%0d", c), out_valid[c], m_valid[c]);
      chk($sformatf("out_data%0d", c), out_data[c*8 +: 8], m_last[c]);
    end
  endtask
  // one cycle: drive at posedge+1, check mid-cycle, advance the model, return at next posedge+1
  task automatic step(input logic [7:0] d, input bit v, input bit sof, input logic [3:0] rdy, output bit acc);
    int  t;
    bit  rdy_exp;
    in_data = d;
    in_valid = v;
    in_sof = sof;
    out_ready = rdy;
    #2;
    t = sof ? 0 : m_sel;
    rdy_exp = !m_locked || !m_valid[t] || rdy[t];
    chk("in_ready", in_ready, rdy_exp);
    check_outputs();
    acc = v && rdy_exp && (m_locked || sof);
    m_serr = acc && sof && m_locked && (m_sel != 0);
    for (int c = 0; c < 4; c++) if (m_valid[c] && rdy[c]) m_valid[c] = 0;
    if (acc) begin
      m_valid[t] = 1;
      m_last[t] = d;
      m_sel = (t + 1) % 4;
      m_locked = 1;
    end
    @(posedge clk);
    #1;
  endtask
  // present one sample until it is taken, bounded
  task automatic send(input logic [7:0] d, input bit sof, input logic [3:0] rdy);
    bit acc = 0;
    for (int i = 0; i < 20 && !acc; i++) step(d, 1'b1, sof, rdy, acc);
    if (!acc) chk("send_timeout", 1, 0);
  endtask
  initial begin
    bit acc;
    rst_n = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    out_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // samples without SOF are ignored while hunting
    step(8'h11, 1, 0, 4'hF, acc);
    step(8'h22, 1, 0, 4'hF, acc);
    step(8'h33, 1, 0, 4'hF, acc);
    // first frame locks
    send(8'hA0, 1, 4'hF);
    send(8'hA1, 0, 4'hF);
    send(8'hA2, 0, 4'hF);
    send(8'hA3, 0, 4'hF);
    step(8'h00, 0, 0, 4'hF, acc);
    // ch2 stalled: second frame's ch2 sample must wait
    send(8'hB0, 1, 4'b1011);
    send(8'hB1, 0, 4'b1011);
    send(8'hB2, 0, 4'b1011);
    send(8'hB3, 0, 4'b1011);
    send(8'hC0, 1, 4'b1011);
    send(8'hC1, 0, 4'b1011);
    repeat (3) step(8'hC2, 1, 0, 4'b1011, acc);
    send(8'hC2, 0, 4'hF);
    send(8'hC3, 0, 4'hF);
    step(8'h00, 0, 0, 4'hF, acc);
    // misaligned SOF at sel=2
    send(8'h40, 1, 4'hF);
    send(8'h41, 0, 4'hF);
    send(8'h5A, 1, 4'hF);
    step(8'h00, 0, 0, 4'hF, acc);
    step(8'h00, 0, 0, 4'hF, acc);
    // back-to-back misalignment pulses
    send(8'h60, 1, 4'hF);
    send(8'h61, 0, 4'hF);
    send(8'h62, 1, 4'hF);
    send(8'h63, 1, 4'hF);
    step(8'h00, 0, 0, 4'hF, acc);
    // ch1 drain and rewrite in the same cycle
    send(8'h70, 1, 4'b1101);
    send(8'h71, 0, 4'b1101);
    send(8'h72, 0, 4'b1101);
    send(8'h73, 0, 4'b1101);
    send(8'h74, 1, 4'b1101);
    send(8'h75, 0, 4'hF);
    step(8'h00, 0, 0, 4'hF, acc);
    step(8'h00, 0, 0, 4'hF, acc);
    // async reset mid-frame with sel=3 and ch0..2 full
    send(8'hD0, 1, 4'h0);
    send(8'hD1, 0, 4'h0);
    send(8'hD2, 0, 4'h0);
    step(8'h00, 0, 0, 4'h0, acc);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(8'hE1, 1, 0, 4'hF, acc);
    step(8'hE2, 1, 0, 4'hF, acc);
    // random traffic
    for (int i = 0; i < 1500; i++)
      step(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 4'($urandom), acc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
